// File: rtl/riscv_alu_serdiv_if.sv
`default_nettype none
// ============================================================================
// Module      : riscv_alu_serdiv_if
// Description : Issue/result bundle for the iterative divider. The issuing
//               pipeline uses the master modport, the divider the slave one.
//   OpA_DI/OpB_DI  dividend / divisor         OpCode_SI  0 udiv 1 div 2 urem 3 rem
//   Tag_DI         opaque tag (e.g. rd)       InVld_SI / InRdy_SO  issue handshake
//   Flush_SI       kill in-flight operation   OutVld_SO / OutRdy_SI result handshake
//   Res_DO         quotient or remainder      Tag_DO     tag of the result
// Revision    : 1.0 - initial release
// ============================================================================
interface riscv_alu_serdiv_if #(
  parameter int C_WIDTH     = 32,
  parameter int C_TAG_WIDTH = 5
);
  logic [C_WIDTH-1:0]     OpA_DI;
  logic [C_WIDTH-1:0]     OpB_DI;
  logic [1:0]             OpCode_SI;
  logic [C_TAG_WIDTH-1:0] Tag_DI;
  logic                   InVld_SI;
  logic                   InRdy_SO;
  logic                   Flush_SI;
  logic                   OutVld_SO;
  logic                   OutRdy_SI;
  logic [C_WIDTH-1:0]     Res_DO;
  logic [C_TAG_WIDTH-1:0] Tag_DO;

  modport master (
    output OpA_DI, OpB_DI, OpCode_SI, Tag_DI, InVld_SI, Flush_SI, OutRdy_SI,
    input  InRdy_SO, OutVld_SO, Res_DO, Tag_DO
  );

  modport slave (
    input  OpA_DI, OpB_DI, OpCode_SI, Tag_DI, InVld_SI, Flush_SI, OutRdy_SI,
    output InRdy_SO, OutVld_SO, Res_DO, Tag_DO
  );
endinterface
`default_nettype wire

// File: rtl/riscv_alu_serdiv.sv
`default_nettype none
// ============================================================================
// Module      : riscv_alu_serdiv
// Description : Radix-2 iterative divider/remainder unit (udiv/div/urem/rem).
//               Operands are normalised with leading-zero counts so that the
//               loop runs only shift+1 cycles; divide-by-zero and |A|<|B|
//               complete immediately.
// Ports       : Clk_CI   clock, rising edge
//               Rst_RBI  synchronous active-low reset
//               Bus      riscv_alu_serdiv_if.slave (operands, handshakes, result)
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_alu_serdiv #(
  parameter int C_WIDTH     = 32,
  parameter int C_LOG_WIDTH = 6,
  parameter int C_TAG_WIDTH = 5
) (
  input  wire logic         Clk_CI,
  input  wire logic         Rst_RBI,
  riscv_alu_serdiv_if.slave Bus
);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_DIVIDE = 2'd1;
  localparam logic [1:0] c_FINISH = 2'd2;

  localparam logic [C_LOG_WIDTH-1:0] c_CNT_ONE = C_LOG_WIDTH'(1);

  // Leading-zero count; an all-zero input returns C_WIDTH.
  function automatic logic [C_LOG_WIDTH-1:0] lzc(input logic [C_WIDTH-1:0] v);
    logic [C_LOG_WIDTH-1:0] n;
    logic                   found;
    n     = '0;
    found = 1'b0;
    for (int i = C_WIDTH - 1; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      n     = n + c_CNT_ONE;
      end
    end
    return n;
  endfunction

  logic [1:0]             r_State;
  logic [C_WIDTH-1:0]     r_Rem;
  logic [C_WIDTH-1:0]     r_Quo;
  logic [C_WIDTH-1:0]     r_Bsh;
  logic [C_LOG_WIDTH-1:0] r_Cnt;
  logic                   r_QNeg;
  logic                   r_RNeg;
  logic                   r_RemSel;
  logic [C_TAG_WIDTH-1:0] r_Tag;
  logic [C_WIDTH-1:0]     r_Res;
  logic [C_TAG_WIDTH-1:0] r_TagOut;

  logic                   w_InRdy;
  logic                   w_Accept;
  logic                   w_Signed;
  logic [C_WIDTH-1:0]     w_AbsA;
  logic [C_WIDTH-1:0]     w_AbsB;
  logic [C_LOG_WIDTH-1:0] w_Shift;
  logic                   w_DivZero;
  logic                   w_Small;
  logic [C_WIDTH-1:0]     w_EarlyRes;
  logic                   w_Ge;
  logic [C_WIDTH-1:0]     w_RemNext;
  logic [C_WIDTH-1:0]     w_QuoNext;
  logic [C_WIDTH-1:0]     w_FinalRes;

  // ---------------------------------------------------------------------------
  // Operand preparation. |MIN| comes out as 2^(W-1) when read as unsigned.
  // ---------------------------------------------------------------------------
  assign w_InRdy   = Rst_RBI & (r_State == c_IDLE) & ~Bus.Flush_SI;
  assign w_Accept  = Bus.InVld_SI & w_InRdy;
  assign w_Signed  = Bus.OpCode_SI[0];
  assign w_AbsA    = (w_Signed & Bus.OpA_DI[C_WIDTH-1]) ? -Bus.OpA_DI : Bus.OpA_DI;
  assign w_AbsB    = (w_Signed & Bus.OpB_DI[C_WIDTH-1]) ? -Bus.OpB_DI : Bus.OpB_DI;
  assign w_DivZero = (Bus.OpB_DI == '0);
  assign w_Small   = (w_AbsA < w_AbsB);
  // Only meaningful when neither early-out applies, i.e. |A| >= |B| > 0,
  // which keeps the difference in 0..W-1 and |B|<<shift within W bits.
  assign w_Shift   = lzc(w_AbsB) - lzc(w_AbsA);

  // Early-out values are passed through without sign correction.
  always_comb begin
    w_EarlyRes = Bus.OpA_DI;
    if (!Bus.OpCode_SI[1]) begin
      w_EarlyRes = w_DivZero ? '1 : '0;
    end
  end

  // ---------------------------------------------------------------------------
  // One restoring-division step per cycle.
  // ---------------------------------------------------------------------------
  assign w_Ge      = (r_Rem >= r_Bsh);
  assign w_RemNext = w_Ge ? (r_Rem - r_Bsh) : r_Rem;
  assign w_QuoNext = {r_Quo[C_WIDTH-2:0], w_Ge};
  // MIN/-1 needs no special case: quotient 2^(W-1) with QNeg=0 is MIN itself.
  assign w_FinalRes = r_RemSel ? (r_RNeg ? -w_RemNext : w_RemNext)
                               : (r_QNeg ? -w_QuoNext : w_QuoNext);

  always_ff @(posedge Clk_CI) begin
    if (!Rst_RBI) begin
      r_State  <= c_IDLE;
      r_Rem    <= '0;
      r_Quo    <= '0;
      r_Bsh    <= '0;
      r_Cnt    <= '0;
      r_QNeg   <= 1'b0;
      r_RNeg   <= 1'b0;
      r_RemSel <= 1'b0;
      r_Tag    <= '0;
      r_Res    <= '0;
      r_TagOut <= '0;
    end else begin
      case (r_State)
        c_IDLE: begin
          if (w_Accept) begin
            r_QNeg   <= w_Signed & (Bus.OpA_DI[C_WIDTH-1] ^ Bus.OpB_DI[C_WIDTH-1]);
            r_RNeg   <= w_Signed & Bus.OpA_DI[C_WIDTH-1];
            r_RemSel <= Bus.OpCode_SI[1];
            r_Tag    <= Bus.Tag_DI;
            if (w_DivZero || w_Small) begin
              r_Res    <= w_EarlyRes;
              r_TagOut <= Bus.Tag_DI;
              r_State  <= c_FINISH;
            end else begin
              r_Bsh   <= w_AbsB << w_Shift;
              r_Rem   <= w_AbsA;
              r_Quo   <= '0;
              r_Cnt   <= w_Shift;
              r_State <= c_DIVIDE;
            end
          end
        end

        c_DIVIDE: begin
          if (Bus.Flush_SI) begin
            r_State <= c_IDLE;
          end else begin
            r_Rem <= w_RemNext;
            r_Quo <= w_QuoNext;
            r_Bsh <= r_Bsh >> 1;
            if (r_Cnt == '0) begin
              r_Res    <= w_FinalRes;
              r_TagOut <= r_Tag;
              r_State  <= c_FINISH;
            end else begin
              r_Cnt <= r_Cnt - c_CNT_ONE;
            end
          end
        end

        c_FINISH: begin
          // A flush coinciding with OutRdy still leaves: the result is dropped.
          if (Bus.Flush_SI || Bus.OutRdy_SI) begin
            r_State <= c_IDLE;
          end
        end

        default: r_State <= c_IDLE;
      endcase
    end
  end

  assign Bus.InRdy_SO  = w_InRdy;
  assign Bus.OutVld_SO = (r_State == c_FINISH);
  assign Bus.Res_DO    = r_Res;
  assign Bus.Tag_DO    = r_TagOut;

endmodule
`default_nettype wire

// File: tb/tb_riscv_alu_serdiv.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_alu_serdiv
// Description : Directed, table-driven bench for riscv_alu_serdiv (W=32).
//               Each vector checks result, tag and accept-to-OutVld latency;
//               hand-written sequences cover backpressure, flush and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_alu_serdiv;

  logic Clk_CI  = 1'b0;
  logic Rst_RBI = 1'b0;

  always #5 Clk_CI = ~Clk_CI;

  riscv_alu_serdiv_if #(.C_WIDTH(32), .C_TAG_WIDTH(5)) bus ();

  riscv_alu_serdiv #(
    .C_WIDTH    (32),
    .C_LOG_WIDTH(6),
    .C_TAG_WIDTH(5)
  ) dut (
    .Clk_CI (Clk_CI),
    .Rst_RBI(Rst_RBI),
    .Bus    (bus)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic [31:0] res;
    int          lat;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  int nTests = 0;
  int nFail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk_CI);
    #1;
  endtask

  // Issue one operation (called #1 after a rising edge) and retire it with
  // OutRdy=1. Latency counts cycles from the accept cycle N to OutVld.
  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] op, input logic [4:0] tag,
                        input logic [31:0] expRes, input int expLat);
    int lat;
    bus.OpA_DI    = a;
    bus.OpB_DI    = b;
    bus.OpCode_SI = op;
    bus.Tag_DI    = tag;
    bus.InVld_SI  = 1'b1;
    bus.OutRdy_SI = 1'b1;
    check({name, " inrdy"}, 32'(bus.InRdy_SO), 32'd1);
    tick();
    bus.InVld_SI = 1'b0;
    lat = 1;
    while (!bus.OutVld_SO && lat < 40) begin
      tick();
      lat++;
    end
    check({name, " lat"}, 32'(lat), 32'(expLat));
    check({name, " res"}, bus.Res_DO, expRes);
    check({name, " tag"}, 32'(bus.Tag_DO), 32'(tag));
    tick();
    check({name, " retire"}, {30'd0, bus.OutVld_SO, bus.InRdy_SO}, 32'b01);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          A             B             op    result        latency
    vecs[0]  = '{32'd100,      32'd7,        2'd0, 32'd14,       6};
    vecs[1]  = '{32'hFFFFFFF9, 32'd2,        2'd1, 32'hFFFFFFFD, 3};
    vecs[2]  = '{32'hFFFFFFF9, 32'd2,        2'd3, 32'hFFFFFFFF, 3};
    vecs[3]  = '{32'd7,        32'hFFFFFFFE, 2'd3, 32'd1,        3};
    vecs[4]  = '{32'hFFFFFFF9, 32'd2,        2'd2, 32'd1,        32};
    vecs[5]  = '{32'd5,        32'd0,        2'd1, 32'hFFFFFFFF, 1};
    vecs[6]  = '{32'd5,        32'd0,        2'd3, 32'd5,        1};
    vecs[7]  = '{32'hFFFFFFFB, 32'd0,        2'd3, 32'hFFFFFFFB, 1};
    vecs[8]  = '{32'h80000000, 32'hFFFFFFFF, 2'd1, 32'h80000000, 33};
    vecs[9]  = '{32'h80000000, 32'hFFFFFFFF, 2'd3, 32'd0,        33};
    vecs[10] = '{32'hFFFFFFFF, 32'd1,        2'd0, 32'hFFFFFFFF, 33};
    vecs[11] = '{32'd3,        32'd10,       2'd0, 32'd0,        1};
    vecs[12] = '{32'd3,        32'd10,       2'd2, 32'd3,        1};
    vecs[13] = '{32'd0,        32'd5,        2'd1, 32'd0,        1};
    vecs[14] = '{32'hFFFFFF9C, 32'd7,        2'd1, 32'hFFFFFFF2, 6};
    vecs[15] = '{32'hFFFFFF9C, 32'd7,        2'd3, 32'hFFFFFFFE, 6};
    vecs[16] = '{32'h80000000, 32'h80000000, 2'd0, 32'd1,        2};

    bus.OpA_DI    = '0;
    bus.OpB_DI    = '0;
    bus.OpCode_SI = '0;
    bus.Tag_DI    = '0;
    bus.InVld_SI  = 1'b0;
    bus.Flush_SI  = 1'b0;
    bus.OutRdy_SI = 1'b1;

    // Reset state
    tick(); tick(); tick();
    check("reset outvld", 32'(bus.OutVld_SO), 32'd0);
    check("reset inrdy",  32'(bus.InRdy_SO),  32'd0);
    check("reset res",    bus.Res_DO,         32'd0);
    check("reset tag",    32'(bus.Tag_DO),    32'd0);
    Rst_RBI = 1'b1;
    #1;
    check("post-reset inrdy", 32'(bus.InRdy_SO), 32'd1);

    // Table-driven vectors; first one is the 100/7 tag 3 case.
    for (int i = 0; i < NVEC; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].op,
             (i == 0) ? 5'd3 : 5'(i + 1), vecs[i].res, vecs[i].lat);
    end

    // Backpressure: result and tag hold, no accept while waiting.
    bus.OpA_DI = 32'd3; bus.OpB_DI = 32'd10; bus.OpCode_SI = 2'd2; bus.Tag_DI = 5'd7;
    bus.InVld_SI = 1'b1; bus.OutRdy_SI = 1'b0;
    tick();
    bus.OpA_DI = 32'd50; bus.OpB_DI = 32'd0; bus.OpCode_SI = 2'd0; bus.Tag_DI = 5'd9;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp%0d outvld", k), 32'(bus.OutVld_SO), 32'd1);
      check($sformatf("bp%0d res", k),    bus.Res_DO,         32'd3);
      check($sformatf("bp%0d tag", k),    32'(bus.Tag_DO),    32'd7);
      check($sformatf("bp%0d inrdy", k),  32'(bus.InRdy_SO),  32'd0);
      tick();
    end
    bus.InVld_SI = 1'b0;
    bus.OutRdy_SI = 1'b1;
    tick();
    check("bp retire", {30'd0, bus.OutVld_SO, bus.InRdy_SO}, 32'b01);

    // Flush during DIVIDE, then a fresh operation.
    bus.OpA_DI = 32'd100; bus.OpB_DI = 32'd7; bus.OpCode_SI = 2'd0; bus.Tag_DI = 5'd4;
    bus.InVld_SI = 1'b1;
    tick();
    bus.InVld_SI = 1'b0;
    tick();
    bus.Flush_SI = 1'b1;
    tick();
    bus.Flush_SI = 1'b0;
    #1;
    check("flush div outvld", 32'(bus.OutVld_SO), 32'd0);
    check("flush div inrdy",  32'(bus.InRdy_SO),  32'd1);
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("flush quiet%0d", k), 32'(bus.OutVld_SO), 32'd0);
    end
    run_op("after flush 9/3", 32'd9, 32'd3, 2'd0, 5'd11, 32'd3, 4);

    // Flush in IDLE blocks the accept of an early-out op.
    bus.OpA_DI = 32'd5; bus.OpB_DI = 32'd0; bus.OpCode_SI = 2'd0; bus.Tag_DI = 5'd12;
    bus.InVld_SI = 1'b1; bus.Flush_SI = 1'b1;
    #1;
    check("flush idle inrdy", 32'(bus.InRdy_SO), 32'd0);
    tick();
    bus.InVld_SI = 1'b0; bus.Flush_SI = 1'b0;
    #1;
    check("flush idle no accept", {30'd0, bus.OutVld_SO, bus.InRdy_SO}, 32'b01);

    // Flush in FINISH under backpressure drops the result.
    bus.OpA_DI = 32'd5; bus.OpB_DI = 32'd0; bus.OpCode_SI = 2'd2; bus.Tag_DI = 5'd13;
    bus.InVld_SI = 1'b1; bus.OutRdy_SI = 1'b0;
    tick();
    bus.InVld_SI = 1'b0;
    check("finish outvld", 32'(bus.OutVld_SO), 32'd1);
    bus.Flush_SI = 1'b1;
    tick();
    bus.Flush_SI = 1'b0;
    bus.OutRdy_SI = 1'b1;
    #1;
    check("flush finish", {30'd0, bus.OutVld_SO, bus.InRdy_SO}, 32'b01);

    // Reset mid-DIVIDE.
    run_op("pre-reset", 32'd200, 32'd7, 2'd0, 5'd21, 32'd28, 7);
    bus.OpA_DI = 32'hFFFFFFFF; bus.OpB_DI = 32'd1; bus.OpCode_SI = 2'd0; bus.Tag_DI = 5'd22;
    bus.InVld_SI = 1'b1;
    tick();
    bus.InVld_SI = 1'b0;
    tick(); tick();
    Rst_RBI = 1'b0;
    tick();
    check("midrst outvld", 32'(bus.OutVld_SO), 32'd0);
    check("midrst res",    bus.Res_DO,         32'd0);
    check("midrst tag",    32'(bus.Tag_DO),    32'd0);
    check("midrst inrdy",  32'(bus.InRdy_SO),  32'd0);
    Rst_RBI = 1'b1;
    #1;
    check("midrst release inrdy", 32'(bus.InRdy_SO), 32'd1);
    for (int k = 0; k < 35; k++) begin
      tick();
      if (bus.OutVld_SO) check($sformatf("midrst ghost%0d", k), 32'(bus.OutVld_SO), 32'd0);
    end
    check("midrst idle", {30'd0, bus.OutVld_SO, bus.InRdy_SO}, 32'b01);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
`default_nettype wire
